// File: rtl/program_counter_unit.sv
// Program counter with byte-wide loads, increment/decrement and relative
// branches. A branch that leaves the current 256-byte page takes one extra
// cycle (FIX) to adjust the high part, during which busy is raised and all
// commands are dropped.
module program_counter_unit #(
  parameter int          ADDR_W       = 16,
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        input_lowbyte,
  input  logic [ADDR_W-9:0] input_highbyte,
  input  logic              load_low,
  input  logic              load_high,
  input  logic              increment,
  input  logic              decrement,
  input  logic              branch_take,
  input  logic [7:0]        branch_offset,
  output logic [7:0]        output_lowbyte,
  output logic [ADDR_W-9:0] output_highbyte,
  output logic              busy,
  output logic              page_cross
);

  localparam int HI_W = ADDR_W - 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FIX  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              busy_q, busy_d;
  logic              page_cross_q, page_cross_d;
  logic              fwd_q, fwd_d;

  logic signed [7:0] offset_s;
  logic [8:0]        lo_sum;

  // 8-bit add of the low byte and the raw offset bits; bit 8 is the carry.
  function automatic logic [8:0] add_low(input logic [7:0] lo, input logic [7:0] off);
    return {1'b0, lo} + {1'b0, off};
  endfunction

  // Forward offsets cross on carry-out, backward offsets cross on no carry (borrow).
  function automatic logic crosses_page(input logic signed [7:0] off, input logic carry);
    return (off < 0) ? ~carry : carry;
  endfunction

  // Step the high part by one in the direction of the crossing, modulo 2^HI_W.
  function automatic logic [HI_W-1:0] step_high(input logic [HI_W-1:0] hi, input logic fwd);
    return fwd ? hi + HI_W'(1) : hi - HI_W'(1);
  endfunction

  assign offset_s = branch_offset;
  assign lo_sum   = add_low(pc_q[7:0], branch_offset);

  // Next-state and next-PC selection: load > branch > increment/decrement.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    busy_d       = 1'b0;
    page_cross_d = 1'b0;
    fwd_d        = fwd_q;
    case (state_q)
      S_IDLE: begin
        if (load_low || load_high) begin
          if (load_low)  pc_d[7:0]        = input_lowbyte;
          if (load_high) pc_d[ADDR_W-1:8] = input_highbyte;
        end else if (branch_take) begin
          pc_d[7:0] = lo_sum[7:0];
          if (crosses_page(offset_s, lo_sum[8])) begin
            state_d      = S_FIX;
            busy_d       = 1'b1;
            page_cross_d = 1'b1;
            fwd_d        = (offset_s >= 0);
          end
        end else if (increment && !decrement) begin
          pc_d = pc_q + ADDR_W'(1);
        end else if (decrement && !increment) begin
          pc_d = pc_q - ADDR_W'(1);
        end
      end
      S_FIX: begin
        pc_d[ADDR_W-1:8] = step_high(pc_q[ADDR_W-1:8], fwd_q);
        state_d          = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset restores the vector and drops any pending fixup.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_VECTOR[ADDR_W-1:0];
      busy_q       <= 1'b0;
      page_cross_q <= 1'b0;
      fwd_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      busy_q       <= busy_d;
      page_cross_q <= page_cross_d;
      fwd_q        <= fwd_d;
    end
  end

  assign output_lowbyte  = pc_q[7:0];
  assign output_highbyte = pc_q[ADDR_W-1:8];
  assign busy            = busy_q;
  assign page_cross      = page_cross_q;

endmodule

// File: doc/program_counter_unit.md
PROGRAM_COUNTER_UNIT -- requirements
Module: program_counter_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning total PC width in bits; legal range 9..16.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 16'hFFFC, meaning the PC value loaded on reset; only bits [ADDR_W-1:0] are used.
REQ-003 HI_W SHALL denote ADDR_W-8, the width of the high part.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port input_lowbyte, input, 8 bits: load data for PC[7:0].
REQ-007 Port input_highbyte, input, HI_W bits: load data for PC[ADDR_W-1:8].
REQ-008 Port load_low, input, 1 bit: write input_lowbyte into PC[7:0].
REQ-009 Port load_high, input, 1 bit: write input_highbyte into PC[ADDR_W-1:8].
REQ-010 Port increment, input, 1 bit: PC <= PC+1.
REQ-011 Port decrement, input, 1 bit: PC <= PC-1.
REQ-012 Port branch_take, input, 1 bit: apply relative branch.
REQ-013 Port branch_offset, input, 8 bits: signed two's-complement branch displacement.
REQ-014 Port output_lowbyte, output, 8 bits: registered PC[7:0].
REQ-015 Port output_highbyte, output, HI_W bits: registered PC[ADDR_W-1:8].
REQ-016 Port busy, output, 1 bit: high while a page-cross fixup is pending; commands are ignored while high.
REQ-017 Port page_cross, output, 1 bit: one-cycle pulse, registered, marking a branch that crossed a page.

Function
REQ-018 Outputs SHALL be direct register outputs; there is no combinational path from any input to any output.
REQ-019 The FSM SHALL have exactly two states: IDLE and FIX.
REQ-020 In IDLE, command priority SHALL be: load (load_low/load_high) > branch_take > increment/decrement.
REQ-021 load_low and load_high SHALL act independently and may both be applied in the same cycle; any load suppresses branch/increment/decrement that cycle.
REQ-022 increment and decrement asserted together with no higher-priority command SHALL leave the PC unchanged.
REQ-023 increment/decrement SHALL operate on the full ADDR_W value with modulo 2^ADDR_W wrap (all-ones+1 -> 0; 0-1 -> all-ones), completing in 1 cycle.
REQ-024 branch_take in IDLE SHALL set PC[7:0] <= PC[7:0] + branch_offset (8-bit modulo); the high part is not changed this cycle.
REQ-025 A page cross SHALL be detected when offset[7]=0 and the 8-bit add carries out, or when offset[7]=1 and the add does not carry out (borrow).
REQ-026 On a page cross, the FSM SHALL go to FIX, with busy=1 and page_cross=1 in the following cycle; with no page cross it stays in IDLE and the branch completes in 1 cycle.
REQ-027 In FIX, the high part SHALL be incremented (forward cross) or decremented (backward cross) modulo 2^HI_W, PC[7:0] held, then the FSM returns to IDLE with busy=0 the next cycle.
REQ-028 All commands presented while busy=1 SHALL be ignored (not queued); the caller holds them until busy=0.
REQ-029 page_cross SHALL be high for exactly the one cycle in which busy first rises.
REQ-030 A branch with offset 0 SHALL leave the PC unchanged and never cross a page.

Reset
REQ-031 When rst=1 at a clock edge, PC SHALL load RESET_VECTOR[ADDR_W-1:0], FSM SHALL enter IDLE, busy=0, page_cross=0, overriding all commands.
REQ-032 Reset asserted while in FIX SHALL abandon the fixup; the high part is not adjusted.

Verification
REQ-033 Reset with default parameters -> output_highbyte=8'hFF, output_lowbyte=8'hFC, busy=0, page_cross=0.
REQ-034 PC=16'hFFFF, increment for 1 cycle -> PC=16'h0000; then decrement -> PC=16'hFFFF; increment+decrement together -> PC unchanged.
REQ-035 PC=16'h12F0, branch_take with offset 8'h20 -> cycle+1: PC=16'h1210, busy=1, page_cross=1; cycle+2: PC=16'h1310, busy=0, page_cross=0; increment held during busy has no effect until busy falls.
REQ-036 PC=16'h1205, branch_take with offset 8'hF0 (-16) -> PC=16'h12F5, then PC=16'h11F5; offset 8'h02 from 16'h1205 -> PC=16'h1207 in 1 cycle with busy never set.
REQ-037 load_low=1, load_high=1, increment=1, branch_take=1 together with data 8'h34/8'hAB -> PC=16'hAB34; load_high alone with 8'h56 -> PC=16'h5634.
REQ-038 rst asserted in the FIX cycle after a forward cross from 16'h12F0 -> PC=RESET_VECTOR, busy=0; repeat with ADDR_W=12, RESET_VECTOR=12'hFFC -> output_highbyte is 4 bits wide, 12'hFFF+1 wraps to 12'h000.
